// File: rtl/obi_axi_master_if.sv
// obi_axi_master_if: AXI4 bus with AW/W/B/AR/R channels and master/slave modports.
interface obi_axi_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 16,
  parameter int USER_WIDTH = 10
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic [3:0]              aw_region;
  logic [5:0]              aw_atop;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic [3:0]              ar_region;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;
  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );
  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/obi_axi_master.sv
// obi_axi_master: bridges an OBI request port to single-beat AXI4 transactions, one outstanding.
module obi_axi_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 16,
  parameter int AXI_USER_WIDTH = 10,
  parameter int AXI_ID         = 0,
  parameter bit INSTR_PORT     = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        wdata_i,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               err_o,
  obi_axi_master_if.master   axi
);
  if (AXI_ADDR_WIDTH != 32 || AXI_DATA_WIDTH != 32) begin : g_width_check
    $error("obi_axi_master supports only 32-bit address and data");
  end
  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R} state_t;
  state_t state, state_n;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        aw_done, w_done, rvalid_q, err_q;
  logic        aw_hs, w_hs, b_hs, r_hs;
  logic        unused_ok;
  assign gnt_o    = req_i & (state == IDLE) & rst_ni;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign axi.aw_valid  = (state == WR) & ~aw_done;
  assign axi.w_valid   = (state == WR) & ~w_done;
  assign axi.b_ready   = (state == WR_B);
  assign axi.ar_valid  = (state == RD_A);
  assign axi.r_ready   = (state == RD_R);
  assign aw_hs = axi.aw_valid & axi.aw_ready;
  assign w_hs  = axi.w_valid & axi.w_ready;
  assign b_hs  = axi.b_ready & axi.b_valid;
  assign r_hs  = axi.r_ready & axi.r_valid;
  assign axi.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign axi.aw_addr   = addr_q;
  assign axi.aw_len    = '0;
  assign axi.aw_size   = 3'b010;
  assign axi.aw_burst  = 2'b01;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = '0;
  assign axi.aw_prot   = '0;
  assign axi.aw_qos    = '0;
  assign axi.aw_region = '0;
  assign axi.aw_atop   = '0;
  assign axi.aw_user   = '0;
  assign axi.w_data    = wdata_q;
  assign axi.w_strb    = be_q;
  assign axi.w_last    = 1'b1;
  assign axi.w_user    = '0;
  assign axi.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign axi.ar_addr   = addr_q;
  assign axi.ar_len    = '0;
  assign axi.ar_size   = 3'b010;
  assign axi.ar_burst  = 2'b01;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = '0;
  assign axi.ar_prot   = {INSTR_PORT, 2'b00};
  assign axi.ar_qos    = '0;
  assign axi.ar_region = '0;
  assign axi.ar_user   = '0;
  assign unused_ok = ^{axi.b_id, axi.b_user, axi.b_resp[0], axi.r_id, axi.r_last, axi.r_user, axi.r_resp[0]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = gnt_o ? (we_i ? WR : RD_A) : IDLE;
      WR:      state_n = ((aw_done | aw_hs) & (w_done | w_hs)) ? WR_B : WR;
      WR_B:    state_n = b_hs ? IDLE : WR_B;
      RD_A:    state_n = axi.ar_ready ? RD_R : RD_A;
      RD_R:    state_n = r_hs ? IDLE : RD_R;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      state    <= state_n;
      aw_done  <= (state == WR) & (aw_done | aw_hs);
      w_done   <= (state == WR) & (w_done | w_hs);
      rvalid_q <= b_hs | r_hs;
      if (gnt_o) begin
        addr_q  <= addr_i;
        be_q    <= be_i;
        wdata_q <= wdata_i;
      end
      if (b_hs) begin
        rdata_q <= '0;
        err_q   <= axi.b_resp[1];
      end
      if (r_hs) begin
        rdata_q <= axi.r_data;
        err_q   <= axi.r_resp[1];
      end
    end
  end
endmodule

// File: tb/tb_obi_axi_master.sv
// tb_obi_axi_master: randomized OBI master + AXI slave with a transaction-level reference model.
module tb_obi_axi_master;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          aw_lat, w_lat, b_lat, ar_lat, r_lat, gap;
  } txn_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  always #5 clk = ~clk;

  obi_axi_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(16), .USER_WIDTH(10)) axi ();
  obi_axi_master #(.INSTR_PORT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .axi(axi.master)
  );

  int checks = 0, failures = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mapped(logic [31:0] a);
    return a[31:28] < 4'd2;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] b);
    logic [31:0] v = old;
    for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction

  function automatic txn_t mk(logic w, logic [31:0] a, logic [3:0] b, logic [31:0] d,
                              int awl, int wl, int bl, int arl, int rl, int g);
    txn_t t;
    t.we = w; t.addr = a; t.be = b; t.wdata = d;
    t.aw_lat = awl; t.w_lat = wl; t.b_lat = bl; t.ar_lat = arl; t.r_lat = rl; t.gap = g;
    return t;
  endfunction

  // Stimulus list (written by main), current issue and current granted transaction.
  txn_t list[$];
  txn_t a_cur, cur;
  int   a_idx = 0, a_gnt_cnt = 0, gap_left = 0;

  // Reference model state and slave bookkeeping (written at negedge).
  logic [31:0] ref_mem[logic [29:0]];
  logic [31:0] slv_mem[logic [29:0]];
  logic [31:0] exp_rdata[$];
  logic        exp_err[$];
  logic [31:0] log_rdata[$];
  logic        log_err[$];
  int          log_lat[$];
  logic busy = 0, resp_prev = 0, aw_done = 0, w_done = 0, ar_done = 0;
  logic pend_b = 0, pend_r = 0, got_aw = 0, got_w = 0;
  logic [31:0] s_awaddr, s_wdata, r_data_v, last_rdata = '0;
  logic [3:0]  s_wstrb, last_wstrb;
  logic [1:0]  b_resp_v, r_resp_v;
  logic        last_err = 0, last_wlast;
  int aw_seen = 0, w_seen = 0, ar_seen = 0, b_seen = 0, r_seen = 0;
  int aw_beats = 0, w_beats = 0, gnt_cnt = 0, rv_cnt = 0, coinc = 0;
  int cyc = 0, gnt_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;

  // Driver: OBI master and AXI slave inputs, updated 1 time unit after each rising edge.
  initial begin
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0; axi.b_valid = 0; axi.r_valid = 0;
    axi.b_id = '0; axi.b_user = '0; axi.b_resp = '0;
    axi.r_id = '0; axi.r_user = '0; axi.r_resp = '0; axi.r_data = '0; axi.r_last = 1;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        req = 0; gap_left = 0; a_gnt_cnt = gnt_cnt;
        axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0; axi.b_valid = 0; axi.r_valid = 0;
      end else begin
        if (req && gnt_cnt != a_gnt_cnt) begin
          a_gnt_cnt = gnt_cnt; req = 0; gap_left = a_cur.gap;
        end else if (!req && gap_left > 0) gap_left--;
        if (!req && gap_left == 0 && a_idx < list.size()) begin
          a_cur = list[a_idx]; a_idx++;
          req = 1; we = a_cur.we; addr = a_cur.addr; be = a_cur.be; wdata = a_cur.wdata;
        end
        axi.aw_ready = axi.aw_valid && aw_seen >= cur.aw_lat;
        axi.w_ready  = axi.w_valid && w_seen >= cur.w_lat;
        axi.ar_ready = axi.ar_valid && ar_seen >= cur.ar_lat;
        axi.b_valid  = pend_b && b_seen >= cur.b_lat;
        axi.b_resp   = axi.b_valid ? b_resp_v : 2'b00;
        axi.r_valid  = pend_r && r_seen >= cur.r_lat;
        axi.r_data   = axi.r_valid ? r_data_v : $urandom();
        axi.r_resp   = axi.r_valid ? r_resp_v : 2'b00;
      end
    end
  end

  // Compare process: checks every DUT output against the model each cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {gnt, rvalid, rdata, err, axi.aw_valid, axi.w_valid, axi.ar_valid,
                            axi.b_ready, axi.r_ready}, '0);
      busy = 0; resp_prev = 0; aw_done = 0; w_done = 0; ar_done = 0;
      pend_b = 0; pend_r = 0; got_aw = 0; got_w = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; b_seen = 0; r_seen = 0;
      exp_rdata.delete(); exp_err.delete(); last_rdata = '0; last_err = 0;
    end else begin
      chk("rvalid", rvalid, resp_prev);
      if (rvalid) begin
        if (exp_rdata.size() == 0) begin
          checks++; failures++;
          $display("FAIL rvalid_unexpected actual=1 expected=0 t=%0t", $time);
        end else begin
          chk("rdata", rdata, exp_rdata.pop_front());
          chk("err", err, exp_err.pop_front());
        end
        log_rdata.push_back(rdata); log_err.push_back(err); log_lat.push_back(cyc - gnt_cyc - 1);
        last_rdata = rdata; last_err = err; rv_cnt++;
      end else chk("rdata_hold", {rdata, err}, {last_rdata, last_err});
      chk("gnt", gnt, req && !busy);
      chk("aw_valid", axi.aw_valid, busy && cur.we && !aw_done);
      chk("w_valid", axi.w_valid, busy && cur.we && !w_done);
      chk("b_ready", axi.b_ready, busy && cur.we && aw_done && w_done);
      chk("ar_valid", axi.ar_valid, busy && !cur.we && !ar_done);
      chk("r_ready", axi.r_ready, busy && !cur.we && ar_done);
      if (axi.aw_valid) begin
        chk("aw_addr", axi.aw_addr, cur.addr);
        chk("aw_id", axi.aw_id, 0);
        chk("aw_fields", {axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_lock, axi.aw_cache, axi.aw_prot,
                          axi.aw_qos, axi.aw_region, axi.aw_atop, axi.aw_user},
                         {8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 10'd0});
      end
      if (axi.w_valid)
        chk("w_beat", {axi.w_data, axi.w_strb, axi.w_last, axi.w_user}, {cur.wdata, cur.be, 1'b1, 10'd0});
      if (axi.ar_valid) begin
        chk("ar_addr", axi.ar_addr, cur.addr);
        chk("ar_id", axi.ar_id, 0);
        chk("ar_fields", {axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_lock, axi.ar_cache, axi.ar_prot,
                          axi.ar_qos, axi.ar_region, axi.ar_user},
                         {8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'b100, 4'd0, 4'd0, 10'd0});
      end
      resp_prev = 0;
      // Handshakes seen here complete on the next rising edge.
      if (pend_b) begin
        if (axi.b_valid && axi.b_ready) begin
          pend_b = 0; busy = 0; resp_prev = 1;
          chk("aw_beats", aw_beats, 1); chk("w_beats", w_beats, 1);
        end else b_seen++;
      end
      if (pend_r) begin
        if (axi.r_valid && axi.r_ready) begin pend_r = 0; busy = 0; resp_prev = 1; end
        else r_seen++;
      end
      if (axi.aw_valid && axi.aw_ready) begin
        aw_done = 1; aw_beats++; s_awaddr = axi.aw_addr; got_aw = 1; aw_seen = 0; aw_hs_cyc = cyc;
      end else if (axi.aw_valid) aw_seen++;
      if (axi.w_valid && axi.w_ready) begin
        w_done = 1; w_beats++; s_wdata = axi.w_data; s_wstrb = axi.w_strb; got_w = 1; w_seen = 0;
        w_hs_cyc = cyc; last_wstrb = axi.w_strb; last_wlast = axi.w_last;
      end else if (axi.w_valid) w_seen++;
      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0; pend_b = 1; b_seen = 0;
        if (mapped(s_awaddr))
          slv_mem[s_awaddr[31:2]] = merge(slv_mem.exists(s_awaddr[31:2]) ? slv_mem[s_awaddr[31:2]] : '0,
                                          s_wdata, s_wstrb);
        b_resp_v = s_awaddr[31:28] == 4'd3 ? 2'b11 : s_awaddr[31:28] == 4'd2 ? 2'b10 : 2'($urandom_range(0, 1));
      end
      if (axi.ar_valid && axi.ar_ready) begin
        ar_done = 1; pend_r = 1; r_seen = 0;
        r_data_v = !mapped(axi.ar_addr) ? '0 : slv_mem.exists(axi.ar_addr[31:2]) ? slv_mem[axi.ar_addr[31:2]] : '0;
        r_resp_v = axi.ar_addr[31:28] == 4'd3 ? 2'b11 : axi.ar_addr[31:28] == 4'd2 ? 2'b10 : 2'($urandom_range(0, 1));
      end else if (axi.ar_valid) ar_seen++;
      if (gnt && req) begin
        if (rvalid) coinc++;
        busy = 1; cur = a_cur; aw_done = 0; w_done = 0; ar_done = 0; aw_beats = 0; w_beats = 0;
        gnt_cnt++; gnt_cyc = cyc;
        if (cur.we) begin
          if (mapped(cur.addr))
            ref_mem[cur.addr[31:2]] = merge(ref_mem.exists(cur.addr[31:2]) ? ref_mem[cur.addr[31:2]] : '0,
                                            cur.wdata, cur.be);
          exp_rdata.push_back('0);
        end else
          exp_rdata.push_back(!mapped(cur.addr) ? '0 :
                              ref_mem.exists(cur.addr[31:2]) ? ref_mem[cur.addr[31:2]] : '0);
        exp_err.push_back(!mapped(cur.addr));
      end
    end
  end

  task automatic wait_rv(int target, int budget);
    int n = 0;
    while (rv_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
    chk("response_count", rv_cnt, target);
    repeat (2) begin @(negedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n, c0;
    logic [31:0] a;
    ref_mem[30'h40] = 32'hDEADBEEF;
    slv_mem[30'h40] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1;
    list.push_back(mk(0, 32'h0000_0100, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    wait_rv(1, 50);
    chk("lit_read_data", log_rdata[0], 32'hDEADBEEF);
    chk("lit_read_err", log_err[0], 0);
    chk("lit_read_latency", log_lat[0], 2);
    list.push_back(mk(1, 32'h1000_0000, 4'b0011, 32'h1234_5678, 3, 0, 0, 0, 0, 0));
    wait_rv(2, 60);
    chk("lit_wr_err", log_err[1], 0);
    chk("lit_wr_rdata", log_rdata[1], 0);
    chk("lit_wr_strb_last", {last_wstrb, last_wlast}, {4'b0011, 1'b1});
    chk("lit_w_before_aw", w_hs_cyc < aw_hs_cyc, 1);
    list.push_back(mk(0, 32'h1000_0000, 4'hF, 0, 0, 0, 0, 0, 1, 0));
    wait_rv(3, 60);
    chk("lit_readback", log_rdata[2], 32'h0000_5678);
    list.push_back(mk(1, 32'h0000_0020, 4'hF, 32'hAABB_CCDD, 0, 0, 0, 0, 0, 0));
    wait_rv(4, 60);
    chk("lit_wr_same_cycle_latency", log_lat[3], 2);
    chk("lit_wr_same_cycle_err", log_err[3], 0);
    list.push_back(mk(0, 32'h3000_0000, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    wait_rv(5, 60);
    chk("lit_decerr", log_err[4], 1);
    c0 = coinc;
    list.push_back(mk(0, 32'h0000_0100, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    list.push_back(mk(1, 32'h0000_0024, 4'b1100, 32'hCAFE_0000, 1, 0, 0, 0, 0, 0));
    list.push_back(mk(0, 32'h0000_0024, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    wait_rv(8, 100);
    chk("lit_b2b_coincident_grants", coinc - c0, 2);
    chk("lit_b2b_data", {log_rdata[5], log_rdata[6], log_rdata[7]}, {32'hDEADBEEF, 32'h0, 32'hCAFE_0000});
    list.push_back(mk(0, 32'h0000_0100, 4'hF, 0, 0, 0, 0, 10, 0, 0));
    n = 0;
    while (!axi.ar_valid && n < 50) begin @(negedge clk); #1; n++; end
    chk("lit_ar_valid_before_reset", axi.ar_valid, 1);
    #2 rst_n = 0;
    #1 chk("lit_reset_immediate", {axi.ar_valid, gnt, rvalid}, 3'b000);
    @(posedge clk); @(posedge clk); #2 rst_n = 1;
    repeat (3) begin @(negedge clk); #1; end
    chk("lit_no_rvalid_after_abort", rv_cnt, 8);
    list.push_back(mk(0, 32'h0000_0100, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    wait_rv(9, 60);
    chk("lit_read_after_reset", log_rdata[8], 32'hDEADBEEF);
    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(0, 3)) << 28) | (32'($urandom_range(0, 15)) << 2) |
          ($urandom_range(0, 7) == 0 ? 32'($urandom_range(1, 3)) : 32'd0);
      list.push_back(mk(1'($urandom_range(0, 1)), a, 4'($urandom_range(1, 15)), $urandom(),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2)));
    end
    wait_rv(49, 2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/obi_axi_master.md
Name: obi_axi_master

Overview:
- Initiator-side bridge that converts the core's OBI-style load/store or fetch request interface into single-beat AXI4 master transactions on an AXI_BUS.Master port.
- One instance sits between each cv32e40p bus port (instruction, data) and the corresponding slave port of the system crossbar.
- At most one transaction is outstanding per instance.
- Write address and write data are issued concurrently; responses are returned to the core as a one-cycle rvalid pulse.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width; must be 32.
- AXI_DATA_WIDTH, 32, AXI data width; must be 32. Other widths are unsupported and the elaboration-time assertion fails.
- AXI_ID_WIDTH, 16, AXI ID width.
- AXI_USER_WIDTH, 10, AXI user width.
- AXI_ID, 0, constant ID placed on aw_id and ar_id.
- INSTR_PORT, 0, when 1, ar_prot[2]=1 (instruction access); otherwise the prot bits are 3'b000.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  1  OBI request.
- gnt_o  output  1  OBI grant (combinational).
- addr_i  input  32  request byte address.
- we_i  input  1  1 = write, 0 = read.
- be_i  input  4  byte enables.
- wdata_i  input  32  write data.
- rvalid_o  output  1  response valid, one-cycle pulse.
- rdata_o  output  32  read data, valid while rvalid_o=1.
- err_o  output  1  bus error, valid while rvalid_o=1.
- axi  interface  AXI_BUS.Master  AXI4 master port (AW/W/B/AR/R channels).

Behaviour:
- Reset (async, rst_ni=0):
  - State = IDLE.
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0.
  - aw_valid, w_valid, ar_valid = 0; b_ready, r_ready = 0.
  - All capture registers are cleared.
- gnt_o = req_i AND state==IDLE AND rst_ni. On a grant edge, capture addr_i, we_i, be_i and wdata_i.
- States:
  - IDLE: on grant, go to WR if we_i=1, else go to RD_A.
  - WR: aw_valid = !aw_done, w_valid = !w_done. aw_done and w_done are set on their respective handshakes; both may complete in the same cycle or in either order. When both are done (counting the current-cycle handshake), go to WR_B.
  - WR_B: b_ready=1. On b_valid, set err = b_resp[1], set rvalid_o=1 on the next cycle, go to IDLE.
  - RD_A: ar_valid=1. On ar_ready, go to RD_R.
  - RD_R: r_ready=1. On r_valid, register rdata_o=r_data and err=r_resp[1], set rvalid_o=1 on the next cycle, go to IDLE.
- Fixed channel fields:
  - aw_addr / ar_addr = captured address (unaligned addresses are passed through unchanged).
  - len=0, size=3'b010, burst=INCR, lock=0, cache=0, qos=0, region=0, atop=0, all user fields=0.
  - w_strb = captured be, w_last=1, w_data = captured wdata.
- AXI valid rules: a valid, once asserted, is held with its payload stable until its ready. A valid never depends combinationally on the corresponding ready.
- rvalid_o is high for exactly one cycle per granted request, in the first IDLE cycle after the response handshake. A new request may be granted in that same cycle.
- For writes, rdata_o = 0. Between responses, rdata_o and err_o hold their last values.
- OKAY and EXOKAY give err_o=0; SLVERR and DECERR give err_o=1.
- Minimum latency is the grant edge plus 2 cycles to rvalid_o for a read with zero-wait ready/valid. Write latency is the same.
- A B or R response that arrives while no request is outstanding cannot occur, because ready is low outside WR_B/RD_R.
- Reset mid-transaction abandons the transaction: all valids drop immediately and no rvalid_o is issued.

Test Plan:
- Read with a slave that answers r_data=32'hDEADBEEF, r_resp=OKAY at addr 32'h0000_0100 with zero wait states -> one AR beat (ar_addr=32'h100, len=0, size=2), then rvalid_o=1 for one cycle with rdata_o=32'hDEADBEEF and err_o=0.
- Write of wdata 32'h1234_5678, be 4'b0011 to 32'h1000_0000, with aw_ready delayed 3 cycles and w_ready immediate -> W completes first and AW valid/addr is held stable. A single B is accepted, then rvalid_o pulses once with err_o=0 and w_strb=4'b0011, w_last=1.
- Write where AW and W handshake in the same cycle -> FSM goes directly to WR_B, exactly one AW and one W beat are issued, and the response is correct.
- Read to an unmapped address 32'h3000_0000 returning DECERR -> rvalid_o=1 with err_o=1.
- Back-to-back requests with req_i held high for 3 requests (read, write, read) -> each grant occurs only in IDLE, the next grant coincides with the previous rvalid_o, and there are 3 rvalid_o pulses in order.
- rst_ni pulsed low while ar_valid=1 -> ar_valid, gnt_o and rvalid_o are 0 immediately; after release the block is in IDLE and the next read completes normally.
